// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: request/response handshake bundle between the memory stage and the data memory
interface data_memory_responder_if;
  logic        request_valid;
  logic        request_ready;
  logic        request_write;
  logic [31:0] request_address;
  logic [31:0] request_writeData;
  logic [3:0]  request_byteStrobe;
  logic        response_valid;
  logic        response_ready;
  logic [31:0] response_readData;
  logic        response_error;
  modport master (
    output request_valid, request_write, request_address, request_writeData, request_byteStrobe, response_ready,
    input  request_ready, response_valid, response_readData, response_error
  );
  modport slave (
    input  request_valid, request_write, request_address, request_writeData, request_byteStrobe, response_ready,
    output request_ready, response_valid, response_readData, response_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: word-addressed data memory with programmable wait states behind a valid/ready request/response pair
// Define DMEM_BYTE_STROBE_EN to make stores honour request_byteStrobe lane enables.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  data_memory_responder_if.slave   bus,
  output logic [1:0]               debug_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  state_t                  r_state, w_next;
  logic [3:0]              r_cnt;
  logic                    r_write, r_err;
  logic [31:0]             r_addr, r_wdata, r_rdata;
  logic                    w_ready, w_accept, w_access, w_write, w_err;
  logic [31:0]             w_addr, w_wdata;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [31:0]             r_mem [2**ADDR_WIDTH];
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]              r_strb, w_strb;
`endif
  // With zero wait states the access happens on the accept edge, so use the live request fields in IDLE
  always_comb begin
    w_ready  = reset && r_state == IDLE;
    w_accept = bus.request_valid && w_ready;
    w_write  = r_state == IDLE ? bus.request_write     : r_write;
    w_addr   = r_state == IDLE ? bus.request_address   : r_addr;
    w_wdata  = r_state == IDLE ? bus.request_writeData : r_wdata;
`ifdef DMEM_BYTE_STROBE_EN
    w_strb   = r_state == IDLE ? bus.request_byteStrobe : r_strb;
`endif
    w_idx    = w_addr[ADDR_WIDTH+1:2];
    w_err    = (|w_addr[1:0]) || (|w_addr[31:ADDR_WIDTH+2]);
    w_access = reset && (r_state == IDLE ? (w_accept && WAIT_CYCLES == 0) : (r_state == WAIT && r_cnt == 4'd0));
    w_next   = r_state == IDLE ? (w_accept ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
               r_state == WAIT ? (r_cnt == 4'd0 ? RESP : WAIT) :
               r_state == RESP ? (bus.response_ready ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge clock)
    r_state <= !reset ? IDLE : w_next;
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= WAIT_INIT;
        r_write <= bus.request_write;
        r_addr  <= bus.request_address;
        r_wdata <= bus.request_writeData;
`ifdef DMEM_BYTE_STROBE_EN
        r_strb  <= bus.request_byteStrobe;
`endif
      end else if (r_state == WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_write) ? '0 : r_mem[w_idx];
      end
    end
  end
  // Array has no reset: contents survive reset and are undefined at power-up
  always_ff @(posedge clock) begin
    if (w_access && w_write && !w_err) begin
`ifdef DMEM_BYTE_STROBE_EN
      for (int i = 0; i < 4; i++)
        if (w_strb[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
`else
      r_mem[w_idx] <= w_wdata;
`endif
    end
  end
  assign bus.request_ready     = w_ready;
  assign bus.response_valid    = r_state == RESP;
  assign bus.response_readData = r_rdata;
  assign bus.response_error    = r_err;
  assign debug_state           = r_state;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed scoreboard bench for data_memory_responder (ADDR_WIDTH=10, WAIT_CYCLES=2)
module tb_data_memory_responder;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] debug_state;
  int         checks = 0, failures = 0, cyc = 0, acc = 0;
  logic [32:0] sq[$];
`ifdef DMEM_BYTE_STROBE_EN
  localparam logic [31:0] STRB_EXP = 32'h11BB11DD;
`else
  localparam logic [31:0] STRB_EXP = 32'hAABBCCDD;
`endif
  data_memory_responder_if bus();
  data_memory_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .bus(bus), .debug_state(debug_state)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit push, input logic e, input logic [31:0] exp);
    int k = 0;
    @(negedge clock);
    bus.request_valid      = 1'b1;
    bus.request_write      = w;
    bus.request_address    = a;
    bus.request_writeData  = d;
    bus.request_byteStrobe = s;
    while (!bus.request_ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("accept_in_time", 32'(k < 50), 32'd1);
    @(posedge clock);
    #1;
    bus.request_valid = 1'b0;
    acc = cyc;
    if (push) sq.push_back({e, exp});
  endtask

  task automatic recv(input int lat, input int hold);
    int k = 0;
    logic [32:0] ex;
    @(negedge clock);
    while (!bus.response_valid && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk("resp_in_time", 32'(k < 50), 32'd1);
    chk("latency", 32'(cyc - acc), 32'(lat));
    chk("sb_nonempty", 32'(sq.size() > 0), 32'd1);
    ex = sq.size() > 0 ? sq.pop_front() : 33'h0_0BAD_0BAD;
    chk("rdata", bus.response_readData, ex[31:0]);
    chk("error", 32'(bus.response_error), 32'(ex[32]));
    chk("req_ready_in_resp", 32'(bus.request_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_valid", 32'(bus.response_valid), 32'd1);
      chk("hold_rdata", bus.response_readData, ex[31:0]);
      chk("hold_req_ready", 32'(bus.request_ready), 32'd0);
    end
    bus.response_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.response_ready = 1'b0;
  endtask

  initial begin
    int seen;
    bus.request_valid      = 1'b0;
    bus.request_write      = 1'b0;
    bus.request_address    = '0;
    bus.request_writeData  = '0;
    bus.request_byteStrobe = '0;
    bus.response_ready     = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 32'(bus.request_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.response_valid), 32'd0);
    chk("rst_rdata", bus.response_readData, 32'd0);
    chk("rst_error", 32'(bus.response_error), 32'd0);
    chk("rst_state", 32'(debug_state), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_req_ready", 32'(bus.request_ready), 32'd1);
    // seed word 0 and word 4
    send(1'b1, 32'h0000_0000, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h0);
    recv(3, 0);
    send(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0);
    recv(3, 0);
    send(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF);
    recv(3, 0);
    // misaligned load, then out-of-range store
    send(1'b0, 32'h0000_0012, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0);
    recv(3, 0);
    send(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF);
    recv(3, 0);
    send(1'b1, 32'h0000_1000, 32'h55555555, 4'hF, 1'b1, 1'b1, 32'h0);
    recv(3, 0);
    send(1'b0, 32'h0000_0000, 32'h0, 4'hF, 1'b1, 1'b0, 32'hCAFEF00D);
    recv(3, 0);
    // backpressure with a competing request held pending
    send(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1, 1'b0, 32'hDEADBEEF);
    bus.request_valid   = 1'b1;
    bus.request_write   = 1'b0;
    bus.request_address = 32'h0000_0000;
    recv(3, 5);
    @(negedge clock);
    chk("idle_after_consume", 32'(debug_state), 32'd0);
    chk("ready_after_consume", 32'(bus.request_ready), 32'd1);
    @(posedge clock);
    #1;
    bus.request_valid = 1'b0;
    acc = cyc;
    sq.push_back({1'b0, 32'hCAFEF00D});
    recv(3, 0);
    // reset during WAIT drops the store
    send(1'b1, 32'h0000_0020, 32'h11111111, 4'hF, 1'b1, 1'b0, 32'h0);
    recv(3, 0);
    send(1'b1, 32'h0000_0020, 32'h12345678, 4'hF, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    chk("state_wait", 32'(debug_state), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_state", 32'(debug_state), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.request_ready), 32'd0);
    reset = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.response_valid) seen++;
    end
    chk("no_resp_after_rst", 32'(seen), 32'd0);
    send(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b1, 1'b0, 32'h11111111);
    recv(3, 0);
    // partial-lane store
    send(1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0, 32'h0);
    recv(3, 0);
    send(1'b0, 32'h0000_0020, 32'h0, 4'hF, 1'b1, 1'b0, STRB_EXP);
    recv(3, 0);
    chk("sb_drained", 32'(sq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
